// File: rtl/gray_pkg.sv
// Shared Gray-code types and helpers for the Gray counter and gray_decoder.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_e;

    // Both helpers work on zero-extended operands, so any width up to
    // GRAY_MAX_W is handled by casting in and truncating the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational WIDTH-bit Gray to binary decode.
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [GRAY_MAX_W-1:0] bin_full;

    assign bin_full = gray2bin(GRAY_MAX_W'(gray_i));
    assign bin_o    = bin_full[WIDTH-1:0];

endmodule

// File: rtl/gray_decoder.sv
// Registered Gray-stream decoder with step classification and wrap detect.
// Optional saturating step-error counter: define GRAY_DEC_ERR_CNT_EN.
//
// state       | meaning
// LOCK_IDLE   | no previous sample; next accepted sample is not checked
// LOCK_LOCKED | bin_q holds the previous sample; steps are classified
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic [1:0]       dir,
    output logic             step_err,
    output logic             wrap
`ifdef GRAY_DEC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic [WIDTH-1:0] bin_dec;
    logic [WIDTH-1:0] diff;

    // bin_q doubles as prev_bin: both load on exactly the same accepted samples.
    logic [WIDTH-1:0] bin_q,       bin_d;
    logic             bin_valid_q, bin_valid_d;
    dir_e             dir_q,       dir_d;
    logic             step_err_q,  step_err_d;
    logic             wrap_q,      wrap_d;
    lock_e            state_q,     state_d;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray_i (gray_in),
        .bin_o  (bin_dec)
    );

    assign diff = bin_dec - bin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOCK_IDLE;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            dir_q       <= DIR_HOLD;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            dir_q       <= dir_d;
            step_err_q  <= step_err_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bin_valid_d = 1'b0;
        dir_d       = dir_q;
        step_err_d  = 1'b0;
        wrap_d      = 1'b0;
        if (gray_valid) begin
            bin_d       = bin_dec;
            bin_valid_d = 1'b1;
            dir_d       = DIR_HOLD;
            state_d     = LOCK_LOCKED;
            // A sync_clr alongside the sample makes it a first sample.
            if (state_q == LOCK_LOCKED && !sync_clr) begin
                if (diff == '0) begin
                    dir_d = DIR_HOLD;
                end else if (diff == WIDTH'(1)) begin
                    dir_d  = DIR_UP;
                    wrap_d = (bin_q == '1);
                end else if (diff == '1) begin
                    dir_d  = DIR_DOWN;
                    wrap_d = (bin_q == '0);
                end else begin
                    step_err_d = 1'b1;
                end
            end
        end else if (sync_clr) begin
            state_d = LOCK_IDLE;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = bin_valid_q;
    assign dir       = dir_q;
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;

`ifdef GRAY_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (sync_clr) begin
            err_cnt_q <= '0;
        end else if (step_err_d && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic [ERR_CNT_W-1:0] unused_err_cnt_w;
    assign unused_err_cnt_w = '0;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder (WIDTH=4) against a behavioural model.
module tb_gray_decoder;

    localparam int W   = 4;
    localparam int N   = 1 << W;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic          gray_valid = 1'b0;
    logic          sync_clr = 1'b0;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic [1:0]    dir;
    logic          step_err;
    logic          wrap;
    logic [CW-1:0] err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int m_bin = 0, m_dir = 0, m_valid = 0, m_err = 0, m_wrap = 0;
    int m_prev = 0, m_have = 0, m_cnt = 0;

    gray_decoder #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .gray_valid (gray_valid),
        .sync_clr   (sync_clr),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .dir        (dir),
        .step_err   (step_err),
        .wrap       (wrap)
`ifdef GRAY_DEC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

`ifndef GRAY_DEC_ERR_CNT_EN
    assign err_cnt = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Binary value whose Gray code is g, found by search rather than XOR chain.
    function automatic int decode(input int g);
        for (int b = 0; b < N; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] enc(input int b);
        int g;
        g = b ^ (b >> 1);
        return g[W-1:0];
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".bin_out"},   32'(bin_out),   32'(m_bin));
        check({tag, ".bin_valid"}, 32'(bin_valid), 32'(m_valid));
        check({tag, ".dir"},       32'(dir),       32'(m_dir));
        check({tag, ".step_err"},  32'(step_err),  32'(m_err));
        check({tag, ".wrap"},      32'(wrap),      32'(m_wrap));
`ifdef GRAY_DEC_ERR_CNT_EN
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_bin = 0; m_dir = 0; m_valid = 0; m_err = 0; m_wrap = 0;
        m_prev = 0; m_have = 0; m_cnt = 0;
    endtask

    task automatic step(input string tag, input bit v, input logic [W-1:0] g, input bit clr);
        int b, d;
        @(negedge clk);
        gray_valid = v;
        gray_in    = g;
        sync_clr   = clr;
        @(posedge clk);
        #1;
        m_valid = v; m_err = 0; m_wrap = 0;
        if (v) begin
            b = decode(int'(g));
            m_dir = 0;
            if (m_have != 0 && !clr) begin
                d = (b - m_prev + N) % N;
                if (d == 1) begin
                    m_dir = 1; m_wrap = (m_prev == N - 1) ? 1 : 0;
                end else if (d == N - 1) begin
                    m_dir = 2; m_wrap = (m_prev == 0) ? 1 : 0;
                end else if (d != 0) begin
                    m_err = 1;
                end
            end
            m_bin = b; m_prev = b; m_have = 1;
        end else if (clr) begin
            m_have = 0;
        end
        if (clr) m_cnt = 0;
        else if (m_err != 0 && m_cnt < CMAX) m_cnt++;
        check_all(tag);
        gray_valid = 1'b0;
        sync_clr   = 1'b0;
    endtask

    initial begin
        int b, r;
        // Reset state
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full up sweep with wrap
        for (int i = 0; i <= N; i++) step("sweep", 1'b1, enc(i % N), 1'b0);
        check("sweep_wrap_last", 32'(wrap), 32'd1);

        // Illegal jump from a fresh lock
        step("ill_clr", 1'b0, '0, 1'b1);
        step("ill_a", 1'b1, 4'b0111, 1'b0);
        step("ill_b", 1'b1, 4'b0010, 1'b0);
        check("ill_bin", 32'(bin_out), 32'd3);
        check("ill_err", 32'(step_err), 32'd1);
        step("ill_relock", 1'b1, 4'b0110, 1'b0);
        check("ill_relock_dir", 32'(dir), 32'd1);

        // Down wrap
        step("dn_a", 1'b1, 4'b0000, 1'b0);
        step("dn_b", 1'b1, 4'b1000, 1'b0);
        check("dn_wrap", 32'(wrap), 32'd1);
        check("dn_dir", 32'(dir), 32'd2);
        step("dn_c", 1'b1, 4'b1001, 1'b0);

        // Hold across a gap
        step("hold_a", 1'b1, 4'b0110, 1'b0);
        for (int i = 0; i < 3; i++) step("gap", 1'b0, 4'b1111, 1'b0);
        check("gap_bin", 32'(bin_out), 32'd4);
        step("hold_b", 1'b1, 4'b0110, 1'b0);

        // Resync, separate and coincident
        step("rs_a", 1'b1, 4'b0101, 1'b0);
        step("rs_clr", 1'b0, '0, 1'b1);
        step("rs_b", 1'b1, 4'b1100, 1'b0);
        step("rs2_a", 1'b1, 4'b0101, 1'b0);
        step("rs2_b", 1'b1, 4'b1100, 1'b1);
        check("rs2_err", 32'(step_err), 32'd0);

        // Random stream: mostly legal neighbours, some jumps, gaps and resyncs
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: b = (m_prev + 1) % N;
                3, 4:    b = (m_prev + N - 1) % N;
                5:       b = m_prev;
                default: b = int'($urandom_range(0, N - 1));
            endcase
            step("rand", ($urandom_range(0, 4) != 0), enc(b), ($urandom_range(0, 15) == 0));
        end

        // Async reset mid-stream
        step("ar_a", 1'b1, 4'b0011, 1'b0);
        step("ar_b", 1'b1, 4'b0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_first", 1'b1, 4'b1111, 1'b0);
        check("ar_first_bin", 32'(bin_out), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
